// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// ID-stage register file with a per-register pending-write scoreboard.
//   - NRD combinational read ports with same-cycle write-back bypass.
//   - NWR synchronous write ports; the highest-numbered port wins an address
//     collision. Register 0 always reads as zero.
//   - Each register r != 0 has a PW-bit counter of in-flight producers.
//     Issue increments it. Write-back or kill decrements it. An underflow
//     clamps the counter at zero and sets the sticky sb_err flag.
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   rd_en/rd_addr            read port qualifiers and addresses (port i at [i*AW +: AW])
//   rd_data/rd_busy          read data and "producer still outstanding" per port
//   wr_en/wr_addr/wr_data    write-back ports
//   iss_en/iss_addr/iss_ok   destination issue and counter-not-saturated flag
//   kill_en/kill_addr        squashed producer, releases one pending count
//   stall                    hazard request to hold ID
//   sb_err                   sticky counter underflow flag
module regfile_scoreboard #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  parameter  int NWR   = 1,
  parameter  int PW    = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic                 iss_ok,
  input  logic                 kill_en,
  input  logic [AW-1:0]        kill_addr,
  output logic                 stall,
  output logic                 sb_err
);

  // The completion count per register can reach NWR+1 (every write port plus a kill).
  localparam int DW = $clog2(NWR + 2);
  // Arithmetic width that holds both cnt+inc and the completion count.
  localparam int SW = ((PW + 1) > DW) ? (PW + 1) : DW;

  logic [XLEN-1:0] reg_arr [NREGS];
  logic [PW-1:0]   cnt_arr [NREGS];
  logic [DW-1:0]   dec_arr [NREGS];
  logic [NREGS-1:0] uf_vec;
  logic            sb_err_q;

  genvar gi;

  // Per-register storage and pending counter
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign reg_arr[gi] = '0;
        assign cnt_arr[gi] = '0;
        assign dec_arr[gi] = '0;
        assign uf_vec[gi]  = 1'b0;
      end else begin : g_live
        logic [XLEN-1:0] reg_q, reg_d;
        logic [PW-1:0]   cnt_q, cnt_d;
        logic [DW-1:0]   dec;
        logic            inc;
        logic            uf;
        logic [SW-1:0]   sum;

        assign inc = iss_en && iss_ok && (iss_addr == AW'(gi));

        // Count the completions to this register in this cycle.
        always_comb begin
          dec = '0;
          for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(gi))) begin
              dec = dec + DW'(1);
            end
          end
          if (kill_en && (kill_addr == AW'(gi))) begin
            dec = dec + DW'(1);
          end
        end

        // Ascending scan, so the highest write port wins a collision.
        always_comb begin
          reg_d = reg_q;
          for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(gi))) begin
              reg_d = wr_data[j*XLEN +: XLEN];
            end
          end
        end

        // Apply cnt + inc - dec. Clamp at zero and flag an underflow.
        always_comb begin
          sum = SW'(cnt_q) + SW'(inc);
          uf  = 1'b0;
          if (sum < SW'(dec)) begin
            cnt_d = '0;
            uf    = 1'b1;
          end else begin
            cnt_d = PW'(sum - SW'(dec));
          end
        end

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            reg_q <= '0;
            cnt_q <= '0;
          end else begin
            reg_q <= reg_d;
            cnt_q <= cnt_d;
          end
        end

        assign reg_arr[gi] = reg_q;
        assign cnt_arr[gi] = cnt_q;
        assign dec_arr[gi] = dec;
        assign uf_vec[gi]  = uf;
      end
    end
  endgenerate

  // Read ports: bypass from same-cycle write-back. A register is busy only if
  // producers remain after this cycle's completions.
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] data;

      assign a = rd_addr[gi*AW +: AW];

      always_comb begin
        data = reg_arr[a];
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == a)) begin
            data = wr_data[j*XLEN +: XLEN];
          end
        end
        if (a == '0) begin
          data = '0;
        end
      end

      assign rd_data[gi*XLEN +: XLEN] = data;
      assign rd_busy[gi] = (a != '0) && (SW'(cnt_arr[a]) > SW'(dec_arr[a]));
    end
  endgenerate

  assign iss_ok = (iss_addr == '0) || (cnt_arr[iss_addr] != {PW{1'b1}});
  assign stall  = (|(rd_en & rd_busy)) || (iss_en && !iss_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_err_q <= 1'b0;
    end else if (|uf_vec) begin
      sb_err_q <= 1'b1;
    end
  end

  assign sb_err = sb_err_q;

endmodule
